// File: rtl/adsr_env_if.sv
// Control and level bus between a voice controller and the ADSR envelope generator.
// The controller drives the gate, retrig and rates; the envelope block returns level and stage.
interface adsr_env_if #(
  parameter int NBITS = 10
);
  logic             gate;
  logic             retrig;
  logic [NBITS-1:0] attack_rate;
  logic [NBITS-1:0] decay_rate;
  logic [NBITS-1:0] sustain_level;
  logic [NBITS-1:0] release_rate;
  logic [NBITS-1:0] env;
  logic [2:0]       stage;
  logic             active;
  logic             tick;

  modport master (
    output gate, retrig, attack_rate, decay_rate, sustain_level, release_rate,
    input  env, stage, active, tick
  );

  modport slave (
    input  gate, retrig, attack_rate, decay_rate, sustain_level, release_rate,
    output env, stage, active, tick
  );
endinterface

// File: rtl/adsr_env.sv
// ADSR envelope generator: gate-keyed level that steps once per divided envelope tick.
// Gate and retrig events take precedence over the tick level update in the same cycle.
module adsr_env #(
  parameter int NBITS    = 10,
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  adsr_env_if.slave  bus
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [NBITS-1:0] LVL_MAX  = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] LVL_ZERO = {NBITS{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } stage_t;

  // Widened add, clamped at full scale.
  function automatic logic [NBITS-1:0] sat_add(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
    logic [NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, LVL_MAX}) return LVL_MAX;
    else                     return s[NBITS-1:0];
  endfunction

  // Widened subtract, clamped at a floor (also covers underflow).
  function automatic logic [NBITS-1:0] sat_sub(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                               input logic [NBITS-1:0] floor_lvl);
    logic [NBITS:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[NBITS] || (d[NBITS-1:0] < floor_lvl)) return floor_lvl;
    else                                         return d[NBITS-1:0];
  endfunction

  logic [CW-1:0]    cnt_r;
  logic             tick_r;
  logic             gate_d_r;
  stage_t           stage_r;
  stage_t           stage_nxt_s;
  logic [NBITS-1:0] env_r;
  logic [NBITS-1:0] env_nxt_s;
  logic             active_r;

  logic             rise_s;
  logic             fall_s;
  logic             retrig_s;
  logic             held_s;
  logic [NBITS-1:0] attack_lvl_s;
  logic [NBITS-1:0] decay_lvl_s;
  logic [NBITS-1:0] release_lvl_s;

  assign rise_s   = bus.gate & ~gate_d_r;
  assign fall_s   = ~bus.gate & gate_d_r;
  assign retrig_s = bus.retrig & bus.gate;
  assign held_s   = (stage_r == ST_ATTACK) || (stage_r == ST_DECAY) || (stage_r == ST_SUSTAIN);

  assign attack_lvl_s  = (bus.attack_rate == LVL_ZERO) ? LVL_MAX : sat_add(env_r, bus.attack_rate);
  assign decay_lvl_s   = (bus.decay_rate == LVL_ZERO) ? bus.sustain_level
                                                      : sat_sub(env_r, bus.decay_rate, bus.sustain_level);
  assign release_lvl_s = (bus.release_rate == LVL_ZERO) ? LVL_ZERO
                                                        : sat_sub(env_r, bus.release_rate, LVL_ZERO);

  // Free-running tick divider, edge-detect register and envelope state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      tick_r   <= 1'b0;
      gate_d_r <= 1'b0;
      stage_r  <= ST_IDLE;
      env_r    <= LVL_ZERO;
      active_r <= 1'b0;
    end else begin
      cnt_r    <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CW'(1);
      tick_r   <= (cnt_r == CNT_LAST);
      gate_d_r <= bus.gate;
      stage_r  <= stage_nxt_s;
      env_r    <= env_nxt_s;
      active_r <= (stage_nxt_s != ST_IDLE);
    end
  end

  // Next stage: fall beats rise/retrig, which beat the tick-driven transition.
  always_comb begin
    stage_nxt_s = stage_r;
    if (fall_s && held_s) begin
      stage_nxt_s = ST_RELEASE;
    end else if (retrig_s || rise_s) begin
      stage_nxt_s = ST_ATTACK;
    end else if (tick_r) begin
      case (stage_r)
        ST_IDLE:    stage_nxt_s = ST_IDLE;
        ST_ATTACK:  stage_nxt_s = (attack_lvl_s == LVL_MAX) ? ST_DECAY : ST_ATTACK;
        ST_DECAY:   stage_nxt_s = (decay_lvl_s == bus.sustain_level) ? ST_SUSTAIN : ST_DECAY;
        ST_SUSTAIN: stage_nxt_s = ST_SUSTAIN;
        ST_RELEASE: stage_nxt_s = (release_lvl_s == LVL_ZERO) ? ST_IDLE : ST_RELEASE;
        default:    stage_nxt_s = ST_IDLE;
      endcase
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  // Next level: events freeze or clear the level; otherwise the tick applies the stage's rate.
  always_comb begin
    env_nxt_s = env_r;
    if (fall_s && held_s) begin
      env_nxt_s = env_r;
    end else if (retrig_s) begin
      env_nxt_s = LVL_ZERO;
    end else if (rise_s) begin
      env_nxt_s = env_r;
    end else if (tick_r) begin
      case (stage_r)
        ST_IDLE:    env_nxt_s = LVL_ZERO;
        ST_ATTACK:  env_nxt_s = attack_lvl_s;
        ST_DECAY:   env_nxt_s = decay_lvl_s;
        ST_SUSTAIN: env_nxt_s = bus.sustain_level;
        ST_RELEASE: env_nxt_s = release_lvl_s;
        default:    env_nxt_s = LVL_ZERO;
      endcase
    end else begin
      env_nxt_s = env_r;
    end
  end

  assign bus.env    = env_r;
  assign bus.stage  = stage_r;
  assign bus.active = active_r;
  assign bus.tick   = tick_r;
endmodule
